int_rx_parser: RTL and testbench

- Parametrised successor to the UART receive-side interface. Pops ASCII characters from the RX FIFO and parses `<A> <op> <B> <term>` expressions.
- Loads operand A, the opcode and operand B one field at a time onto a shared bus toward the ALU register bank, steered by a one-hot select.
- Adds generic operand width, a digit limit, overflow and syntax error detection, an explicit terminator, whitespace skipping, and per-field load strobes.

---
 rtl/int_rx_parser.sv | 118 +++++++++++
 tb/tb_int_rx_parser.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/int_rx_parser.sv
// int_rx_parser: parses "<A> <op> <B> <term>" ASCII expressions from an RX FIFO into ALU field loads
module int_rx_parser #(
    parameter int NBIT       = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            FIFO_empty,
    input  logic [7:0]      data_in,
    output logic            RD_FIFO,
    output logic [NBIT-1:0] data_out,
    output logic [2:0]      SEL,
    output logic            LOAD,
    output logic            DONE,
    output logic            ERR,
    output logic [1:0]      ERR_CODE
);
    typedef enum logic [1:0] {IDLE, DATA_A, OPER, DATA_B} state_t;
    state_t state;
    logic [NBIT-1:0] acc;
    logic [3:0]      cnt;
    logic [7:0]      op;
    logic            consume, is_digit, is_space, is_term, is_op, in_data;
    logic [3:0]      digit;
    logic [7:0]      opcode;
    logic [NBIT+3:0] next_acc;
    logic [1:0]      dig_err, ecode;
    always_comb begin
        consume  = !FIFO_empty && !RD_FIFO;
        is_digit = data_in >= 8'h30 && data_in <= 8'h39;
        is_space = data_in == 8'h20;
        is_term  = data_in == 8'h3D || data_in == 8'h0D;
        digit    = data_in[3:0];
        opcode   = data_in == 8'h2B ? 8'h20 :
                   data_in == 8'h3E ? 8'h21 :
                   data_in == 8'h2D ? 8'h22 :
                   data_in == 8'h3F ? 8'h23 :
                   data_in == 8'h26 ? 8'h24 :
                   data_in == 8'h5E ? 8'h25 :
                   data_in == 8'h78 ? 8'h26 :
                   data_in == 8'h7E ? 8'h27 : 8'h00;
        is_op    = opcode != 8'h00;
        in_data  = state == DATA_A || state == DATA_B;
        // acc*10 + digit; four guard bits always hold the worst case
        next_acc = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{NBIT{1'b0}}, digit};
        dig_err  = cnt == 4'(MAX_DIGITS) ? 2'b11 : |next_acc[NBIT+3:NBIT] ? 2'b10 : 2'b00;
        ecode    = is_digit ? (in_data ? dig_err : 2'b00) :
                   (is_space || (is_term && state != DATA_A && state != OPER) ||
                    (is_op && state == DATA_A)) ? 2'b00 : 2'b01;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            op       <= '0;
            data_out <= '0;
            SEL      <= 3'b000;
            RD_FIFO  <= 1'b0;
            LOAD     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= 2'b00;
        end else begin
            RD_FIFO <= consume;
            LOAD    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            if (consume && !is_space) begin
                if (ecode != 2'b00) begin
                    ERR      <= 1'b1;
                    ERR_CODE <= ecode;
                    acc      <= '0;
                    cnt      <= '0;
                    state    <= IDLE;
                end else begin
                    case (state)
                        IDLE: if (is_digit) begin
                            acc   <= NBIT'(digit);
                            cnt   <= 4'd1;
                            state <= DATA_A;
                        end
                        DATA_A: if (is_digit) begin
                            acc <= next_acc[NBIT-1:0];
                            cnt <= cnt + 4'd1;
                        end else begin
                            data_out <= acc;
                            SEL      <= 3'b001;
                            LOAD     <= 1'b1;
                            op       <= opcode;
                            state    <= OPER;
                        end
                        OPER: begin
                            data_out <= NBIT'(op);
                            SEL      <= 3'b100;
                            LOAD     <= 1'b1;
                            acc      <= NBIT'(digit);
                            cnt      <= 4'd1;
                            state    <= DATA_B;
                        end
                        DATA_B: if (is_digit) begin
                            acc <= next_acc[NBIT-1:0];
                            cnt <= cnt + 4'd1;
                        end else begin
                            data_out <= acc;
                            SEL      <= 3'b010;
                            LOAD     <= 1'b1;
                            DONE     <= 1'b1;
                            acc      <= '0;
                            cnt      <= '0;
                            state    <= IDLE;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_int_rx_parser.sv
// tb_int_rx_parser: directed expression streams into an 8-bit and a 16-bit parser sharing one FIFO model
module tb_int_rx_parser;
    logic        CLK = 0, RESET, FIFO_empty;
    logic [7:0]  data_in;
    logic        rd8, ld8, dn8, er8, rd16, ld16, dn16, er16;
    logic [7:0]  do8;
    logic [15:0] do16;
    logic [2:0]  sel8, sel16;
    logic [1:0]  ec8, ec16;
    int          pass_cnt = 0, total = 0;
    logic [34:0] l8[$], l16[$];
    int          e8[$], e16[$], rd_cyc[$];
    int          done8, done16, dl8;

    int_rx_parser dut8 (
        .CLK(CLK), .RESET(RESET), .FIFO_empty(FIFO_empty), .data_in(data_in), .RD_FIFO(rd8),
        .data_out(do8), .SEL(sel8), .LOAD(ld8), .DONE(dn8), .ERR(er8), .ERR_CODE(ec8)
    );
    int_rx_parser #(.NBIT(16), .MAX_DIGITS(5)) dut16 (
        .CLK(CLK), .RESET(RESET), .FIFO_empty(FIFO_empty), .data_in(data_in), .RD_FIFO(rd16),
        .data_out(do16), .SEL(sel16), .LOAD(ld16), .DONE(dn16), .ERR(er16), .ERR_CODE(ec16)
    );

    always #5 CLK = ~CLK;

    // Pop timing is character-independent, so dut8's RD_FIFO drives the shared FIFO head
    task automatic run(input string s, input bit jitter);
        int idx = 0, post = 0;
        l8.delete(); l16.delete(); e8.delete(); e16.delete(); rd_cyc.delete();
        done8 = 0; done16 = 0; dl8 = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (ld8) l8.push_back({sel8, 32'(do8)});
            if (ld16) l16.push_back({sel16, 32'(do16)});
            if (er8) e8.push_back(int'(ec8));
            if (er16) e16.push_back(int'(ec16));
            if (dn8) done8++;
            if (dn16) done16++;
            if (dn8 && ld8) dl8++;
            if (rd8) begin rd_cyc.push_back(c); idx++; end
            if (idx >= s.len()) begin
                FIFO_empty = 1; data_in = 8'h00; post++;
                if (post > 4) break;
            end else begin
                FIFO_empty = jitter ? ($urandom_range(0, 2) == 0) : 1'b0;
                data_in = s[idx];
            end
            if (c == 399) begin
                total++;
                $display("FAIL timeout on \"%s\": consumed %0d of %0d", s, idx, s.len());
            end
        end
    endtask

    task automatic test_reset;
        RESET = 1; FIFO_empty = 1; data_in = 8'h00;
        repeat (2) @(negedge CLK);
        total++;
        if ({rd8, do8, sel8, ld8, dn8, er8, ec8} !== '0) $display("FAIL reset8 got %b want 0", {rd8, do8, sel8, ld8, dn8, er8, ec8});
        else pass_cnt++;
        total++;
        if ({rd16, do16, sel16, ld16, dn16, er16, ec16} !== '0) $display("FAIL reset16 got %b want 0", {rd16, do16, sel16, ld16, dn16, er16, ec16});
        else pass_cnt++;
        RESET = 0;
    endtask

    task automatic test_basic;
        logic [34:0] exp [3] = '{{3'b001, 32'd12}, {3'b100, 32'h20}, {3'b010, 32'd34}};
        run("12+34=", 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= l8.size() || l8[i] !== exp[i]) $display("FAIL basic_load%0d got %h want %h", i, i < l8.size() ? l8[i] : 'x, exp[i]);
            else pass_cnt++;
        end
        total++;
        if (l8.size() != 3 || dl8 != 1 || done8 != 1) $display("FAIL basic_done loads %0d done %0d with_load %0d want 3/1/1", l8.size(), done8, dl8);
        else pass_cnt++;
        total++;
        if (rd_cyc.size() != 6) $display("FAIL basic_rd_count got %0d want 6", rd_cyc.size());
        else pass_cnt++;
        for (int i = 1; i < rd_cyc.size(); i++) begin
            total++;
            if (rd_cyc[i] - rd_cyc[i-1] != 2) $display("FAIL basic_rd_gap%0d got %0d want 2", i, rd_cyc[i] - rd_cyc[i-1]);
            else pass_cnt++;
        end
        total++;
        if (e8.size() != 0) $display("FAIL basic_err got %0d errors want 0", e8.size());
        else pass_cnt++;
    endtask

    task automatic test_spaces;
        logic [34:0] exp [3] = '{{3'b001, 32'd7}, {3'b100, 32'h27}, {3'b010, 32'd255}};
        run(" 7 ~ 255\r", 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= l8.size() || l8[i] !== exp[i]) $display("FAIL spaces_load%0d got %h want %h", i, i < l8.size() ? l8[i] : 'x, exp[i]);
            else pass_cnt++;
        end
        total++;
        if (done8 != 1 || e8.size() != 0 || rd_cyc.size() != 9) $display("FAIL spaces_status done %0d errs %0d pops %0d want 1/0/9", done8, e8.size(), rd_cyc.size());
        else pass_cnt++;
    endtask

    task automatic test_overflow;
        logic [34:0] exp [3] = '{{3'b001, 32'd256}, {3'b100, 32'h20}, {3'b010, 32'd1}};
        run("256+1=", 1);
        total++;
        if (l8.size() != 0) $display("FAIL ovf_noload got %0d loads want 0", l8.size());
        else pass_cnt++;
        total++;
        if (e8.size() != 3 || e8[0] != 2 || e8[1] != 1 || e8[2] != 1) $display("FAIL ovf_codes got n=%0d first=%0d want 3 errors 2,1,1", e8.size(), e8.size() > 0 ? e8[0] : -1);
        else pass_cnt++;
        total++;
        if (ec8 !== 2'b01) $display("FAIL ovf_code_held got %b want 01", ec8);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= l16.size() || l16[i] !== exp[i]) $display("FAIL ovf_wide_load%0d got %h want %h", i, i < l16.size() ? l16[i] : 'x, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_digits;
        logic [34:0] exp [3] = '{{3'b001, 32'd65535}, {3'b100, 32'h24}, {3'b010, 32'd1}};
        run("0012+1=", 0);
        total++;
        if (l8.size() != 0 || e8.size() != 3 || e8[0] != 3) $display("FAIL digits_limit loads %0d errs %0d first %0d want 0/3/3", l8.size(), e8.size(), e8.size() > 0 ? e8[0] : -1);
        else pass_cnt++;
        run("65535&1=", 1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= l16.size() || l16[i] !== exp[i]) $display("FAIL wide_load%0d got %h want %h", i, i < l16.size() ? l16[i] : 'x, exp[i]);
            else pass_cnt++;
        end
        total++;
        if (done16 != 1 || e16.size() != 0) $display("FAIL wide_done done %0d errs %0d want 1/0", done16, e16.size());
        else pass_cnt++;
    endtask

    task automatic test_bad_char;
        logic [34:0] exp [3] = '{{3'b001, 32'd3}, {3'b100, 32'h22}, {3'b010, 32'd2}};
        run("5+a", 0);
        total++;
        if (l8.size() != 1 || l8[0] !== {3'b001, 32'd5}) $display("FAIL bad_loadA got n=%0d want 1 load of 5", l8.size());
        else pass_cnt++;
        total++;
        if (e8.size() != 1 || e8[0] != 1) $display("FAIL bad_err got n=%0d want one code 1", e8.size());
        else pass_cnt++;
        total++;
        if (do8 !== 8'd5 || sel8 !== 3'b001) $display("FAIL bad_hold got %0d/%b want 5/001", do8, sel8);
        else pass_cnt++;
        run("3-2=", 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= l8.size() || l8[i] !== exp[i]) $display("FAIL recover_load%0d got %h want %h", i, i < l8.size() ? l8[i] : 'x, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        logic [34:0] exp [3] = '{{3'b001, 32'd4}, {3'b100, 32'h21}, {3'b010, 32'd1}};
        run("9x", 1);
        total++;
        if (l8.size() != 1 || l8[0] !== {3'b001, 32'd9}) $display("FAIL mid_loadA got n=%0d want 1 load of 9", l8.size());
        else pass_cnt++;
        @(negedge CLK);
        RESET = 1;
        @(negedge CLK);
        total++;
        if ({rd8, do8, sel8, ld8, dn8, er8, ec8} !== '0) $display("FAIL mid_reset got %b want 0", {rd8, do8, sel8, ld8, dn8, er8, ec8});
        else pass_cnt++;
        RESET = 0;
        run("1=", 1);
        total++;
        if (l8.size() != 0 || e8.size() != 1) $display("FAIL mid_discard loads %0d errs %0d want 0/1", l8.size(), e8.size());
        else pass_cnt++;
        run("4>1=", 1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= l8.size() || l8[i] !== exp[i]) $display("FAIL after_reset_load%0d got %h want %h", i, i < l8.size() ? l8[i] : 'x, exp[i]);
            else pass_cnt++;
        end
        total++;
        if (done8 != 1 || e8.size() != 0) $display("FAIL after_reset_done done %0d errs %0d want 1/0", done8, e8.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_spaces();
        test_overflow();
        test_digits();
        test_bad_char();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
